// File: rtl/button_pkg.sv
// Shared definitions for the button UI blocks: gesture FSM state encoding
// and default timing constants for the 27 MHz system clock.
package button_pkg;

  typedef enum logic [2:0] {
    ST_LOCKOUT = 3'd0,
    ST_IDLE    = 3'd1,
    ST_PRESS1  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_WAIT2   = 3'd4,
    ST_PRESS2  = 3'd5
  } gesture_state_e;

  localparam int unsigned CLK_HZ            = 32'd27_000_000;
  localparam int unsigned DEF_LONG_CYCLES   = 32'd27_000_000;  // 1 s
  localparam int unsigned DEF_REPEAT_CYCLES = 32'd5_400_000;   // 200 ms
  localparam int unsigned DEF_DCLICK_CYCLES = 32'd8_100_000;   // 300 ms

  // Counter width able to hold the largest of the three gesture windows.
  function automatic int unsigned timer_width(input int unsigned a,
                                               input int unsigned b,
                                               input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m) + 32'd1;
  endfunction

endpackage

// File: rtl/gesture_timer.sv
// Saturating up-counter for the gesture windows; hit_o flags count == limit_i
// so the FSM can pick a different window per state.
module gesture_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic             hit_o
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = (cnt_q == limit_i);

endmodule

// File: rtl/button_gesture_ctrl.sv
// Turns a debounced button level into single-cycle UI events: short press,
// double click, long press and auto-repeat while held.
module button_gesture_ctrl
  import button_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int unsigned DCLICK_CYCLES = DEF_DCLICK_CYCLES,
  parameter bit          EN_DOUBLE     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_level_i,
  output logic pressed_o,
  output logic short_press_o,
  output logic double_click_o,
  output logic long_press_o,
  output logic repeat_tick_o,
  output logic busy_o
);

  localparam int unsigned CNT_W = timer_width(LONG_CYCLES, REPEAT_CYCLES, DCLICK_CYCLES);
  // The timer reads limit-1 on the edge where the window elapses.
  localparam logic [CNT_W-1:0] LIM_LONG   = CNT_W'(LONG_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] LIM_REPEAT = CNT_W'(REPEAT_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] LIM_DCLICK = CNT_W'(DCLICK_CYCLES - 32'd1);

  gesture_state_e state_q, state_d;
  logic btn_q, btn_d;
  logic short_q, short_d;
  logic dclick_q, dclick_d;
  logic long_q, long_d;
  logic rep_q, rep_d;
  logic busy_q, busy_d;
  logic short_pend_q, short_pend_d;
  logic dclick_pend_q, dclick_pend_d;

  logic             tmr_clr;
  logic             tmr_en;
  logic             tmr_hit;
  logic [CNT_W-1:0] tmr_limit;

  gesture_timer #(
    .WIDTH (CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (tmr_clr),
    .en_i    (tmr_en),
    .limit_i (tmr_limit),
    .hit_o   (tmr_hit)
  );

  always_comb begin
    state_d       = state_q;
    short_d       = short_pend_q;
    dclick_d      = dclick_pend_q;
    long_d        = 1'b0;
    rep_d         = 1'b0;
    short_pend_d  = 1'b0;
    dclick_pend_d = 1'b0;
    tmr_en        = 1'b0;
    tmr_limit     = '0;
    case (state_q)
      ST_LOCKOUT: begin
        if (!btn_level_i) state_d = ST_IDLE;
        else              state_d = ST_LOCKOUT;
      end
      ST_IDLE: begin
        if (btn_level_i) state_d = ST_PRESS1;
        else             state_d = ST_IDLE;
      end
      ST_PRESS1: begin
        tmr_en    = 1'b1;
        tmr_limit = LIM_LONG;
        // Release wins over the long-press deadline on the same edge.
        if (!btn_level_i) begin
          if (EN_DOUBLE) begin
            state_d = ST_WAIT2;
          end else begin
            state_d      = ST_IDLE;
            short_pend_d = 1'b1;
          end
        end else if (tmr_hit) begin
          long_d  = 1'b1;
          state_d = ST_HOLD;
        end else begin
          state_d = ST_PRESS1;
        end
      end
      ST_HOLD: begin
        tmr_en    = 1'b1;
        tmr_limit = LIM_REPEAT;
        if (!btn_level_i)  state_d = ST_IDLE;
        else if (tmr_hit)  rep_d   = 1'b1;
        else               state_d = ST_HOLD;
      end
      ST_WAIT2: begin
        tmr_en    = 1'b1;
        tmr_limit = LIM_DCLICK;
        // Timeout wins over a press on the same edge; IDLE takes the press.
        if (tmr_hit) begin
          short_d = 1'b1;
          state_d = ST_IDLE;
        end else if (btn_level_i) begin
          dclick_pend_d = 1'b1;
          state_d       = ST_PRESS2;
        end else begin
          state_d = ST_WAIT2;
        end
      end
      ST_PRESS2: begin
        if (!btn_level_i) state_d = ST_IDLE;
        else              state_d = ST_PRESS2;
      end
      default: begin
        state_d = ST_LOCKOUT;
      end
    endcase
    tmr_clr = (state_d != state_q) || rep_d;
    btn_d   = btn_level_i && (state_q != ST_LOCKOUT);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_LOCKOUT;
      btn_q         <= 1'b0;
      short_q       <= 1'b0;
      dclick_q      <= 1'b0;
      long_q        <= 1'b0;
      rep_q         <= 1'b0;
      busy_q        <= 1'b0;
      short_pend_q  <= 1'b0;
      dclick_pend_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      btn_q         <= btn_d;
      short_q       <= short_d;
      dclick_q      <= dclick_d;
      long_q        <= long_d;
      rep_q         <= rep_d;
      busy_q        <= busy_d;
      short_pend_q  <= short_pend_d;
      dclick_pend_q <= dclick_pend_d;
    end
  end

  assign pressed_o      = btn_q;
  assign short_press_o  = short_q;
  assign double_click_o = dclick_q;
  assign long_press_o   = long_q;
  assign repeat_tick_o  = rep_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_button_gesture_ctrl.sv
// Self-checking bench for button_gesture_ctrl: directed gesture scenarios plus
// random press/release runs against a timestamp-based gesture model.
module tb_button_gesture_ctrl;

  localparam int LONG = 8;
  localparam int REP  = 4;
  localparam int DCL  = 6;

  localparam int M_LOCK  = 0;
  localparam int M_IDLE  = 1;
  localparam int M_HELD1 = 2;
  localparam int M_HOLD  = 3;
  localparam int M_WAIT  = 4;
  localparam int M_HELD2 = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn = 1'b0;
  logic pressed, short_press, double_click, long_press, repeat_tick, busy;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  int         m_mode;
  int         m_t0;
  bit         m_dpend;
  logic [5:0] exp_v;

  button_gesture_ctrl #(
    .LONG_CYCLES   (LONG),
    .REPEAT_CYCLES (REP),
    .DCLICK_CYCLES (DCL),
    .EN_DOUBLE     (1'b1)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .btn_level_i    (btn),
    .pressed_o      (pressed),
    .short_press_o  (short_press),
    .double_click_o (double_click),
    .long_press_o   (long_press),
    .repeat_tick_o  (repeat_tick),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] obs_v();
    return {pressed, short_press, double_click, long_press, repeat_tick, busy};
  endfunction

  task automatic model_reset();
    m_mode  = M_LOCK;
    m_t0    = 0;
    m_dpend = 1'b0;
    exp_v   = 6'b0;
  endtask

  // Gesture rules expressed as elapsed edges since the last press/release.
  task automatic model_step(input logic b);
    bit p, s, d, l, r;
    d = m_dpend;
    m_dpend = 1'b0;
    s = 1'b0; l = 1'b0; r = 1'b0;
    p = b && (m_mode != M_LOCK);
    case (m_mode)
      M_LOCK:  if (!b) m_mode = M_IDLE;
      M_IDLE:  if (b) begin m_mode = M_HELD1; m_t0 = edge_n; end
      M_HELD1: begin
        if (!b) begin
          m_mode = M_WAIT; m_t0 = edge_n;
        end else if (edge_n - m_t0 == LONG) begin
          l = 1'b1; m_mode = M_HOLD; m_t0 = edge_n;
        end
      end
      M_HOLD: begin
        if (!b) m_mode = M_IDLE;
        else if ((edge_n - m_t0) % REP == 0) r = 1'b1;
      end
      M_WAIT: begin
        if (edge_n - m_t0 == DCL) begin
          s = 1'b1; m_mode = M_IDLE;
        end else if (b) begin
          m_dpend = 1'b1; m_mode = M_HELD2;
        end
      end
      M_HELD2: if (!b) m_mode = M_IDLE;
      default: m_mode = M_LOCK;
    endcase
    exp_v = {p, s, d, l, r, (m_mode != M_IDLE)};
  endtask

  task automatic cyc(input logic b);
    btn = b;
    @(posedge clk);
    edge_n++;
    #1;
    model_step(b);
  endtask

  task automatic test_reset();
    btn = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs_v() !== 6'b0) begin
      errors++; $display("FAIL reset_outputs: got %b want %b", obs_v(), 6'b0);
    end
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0);
      checks++;
      if (obs_v() !== exp_v) begin
        errors++; $display("FAIL reset_idle i=%0d: got %b want %b", i, obs_v(), exp_v);
      end
    end
  endtask

  task automatic test_short_press();
    int sp_at, n_ev;
    sp_at = -1; n_ev = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(i < 3);
      checks++;
      if (obs_v() !== exp_v) begin
        errors++; $display("FAIL short i=%0d: got %b want %b", i, obs_v(), exp_v);
      end
      if (short_press) sp_at = i;
      n_ev += int'(short_press) + int'(double_click) + int'(long_press) + int'(repeat_tick);
    end
    checks++;
    if (sp_at !== 3 + DCL) begin
      errors++; $display("FAIL short_timing: got edge %0d want %0d", sp_at, 3 + DCL);
    end
    checks++;
    if (n_ev !== 1) begin
      errors++; $display("FAIL short_event_count: got %0d want 1", n_ev);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL short_busy_after: got %b want 0", busy);
    end
  endtask

  task automatic test_double_click();
    int dc_at, n_short;
    dc_at = -1; n_short = 0;
    for (int i = 0; i < 16; i++) begin
      cyc((i < 2) || (i == 4) || (i == 5));
      checks++;
      if (obs_v() !== exp_v) begin
        errors++; $display("FAIL dclick i=%0d: got %b want %b", i, obs_v(), exp_v);
      end
      if (double_click) dc_at = i;
      n_short += int'(short_press);
    end
    checks++;
    if (dc_at !== 5) begin
      errors++; $display("FAIL dclick_timing: got edge %0d want 5", dc_at);
    end
    checks++;
    if (n_short !== 0) begin
      errors++; $display("FAIL dclick_no_short: got %0d want 0", n_short);
    end
  endtask

  task automatic test_long_hold();
    int lp_at, n_rep, n_short, rep_bad;
    lp_at = -1; n_rep = 0; n_short = 0; rep_bad = 0;
    for (int i = 0; i < 37; i++) begin
      cyc(i < 25);
      checks++;
      if (obs_v() !== exp_v) begin
        errors++; $display("FAIL long i=%0d: got %b want %b", i, obs_v(), exp_v);
      end
      if (long_press) lp_at = i;
      if (repeat_tick) begin
        if (i != LONG + REP * (n_rep + 1)) rep_bad++;
        n_rep++;
      end
      n_short += int'(short_press);
    end
    checks++;
    if (lp_at !== LONG) begin
      errors++; $display("FAIL long_timing: got edge %0d want %0d", lp_at, LONG);
    end
    checks++;
    if ((n_rep !== 4) || (rep_bad !== 0)) begin
      errors++; $display("FAIL repeat_ticks: got %0d (%0d misplaced) want 4 (0)", n_rep, rep_bad);
    end
    checks++;
    if (n_short !== 0) begin
      errors++; $display("FAIL long_no_short: got %0d want 0", n_short);
    end
  endtask

  task automatic test_race_long();
    int sp_at, n_long;
    sp_at = -1; n_long = 0;
    for (int i = 0; i < 18; i++) begin
      cyc(i < LONG);
      checks++;
      if (obs_v() !== exp_v) begin
        errors++; $display("FAIL race_long i=%0d: got %b want %b", i, obs_v(), exp_v);
      end
      if (short_press) sp_at = i;
      n_long += int'(long_press);
    end
    checks++;
    if ((n_long !== 0) || (sp_at !== LONG + DCL)) begin
      errors++; $display("FAIL race_long_result: got long=%0d short@%0d want long=0 short@%0d",
                         n_long, sp_at, LONG + DCL);
    end
  endtask

  task automatic test_race_wait2();
    int first_sp, n_short, n_dc;
    first_sp = -1; n_short = 0; n_dc = 0;
    for (int i = 0; i < 22; i++) begin
      cyc((i < 2) || ((i >= 8) && (i < 11)));
      checks++;
      if (obs_v() !== exp_v) begin
        errors++; $display("FAIL race_wait2 i=%0d: got %b want %b", i, obs_v(), exp_v);
      end
      if (short_press && (first_sp < 0)) first_sp = i;
      n_short += int'(short_press);
      n_dc    += int'(double_click);
    end
    checks++;
    if ((first_sp !== 2 + DCL) || (n_short !== 2) || (n_dc !== 0)) begin
      errors++; $display("FAIL race_wait2_result: got short@%0d shorts=%0d dclicks=%0d want short@%0d shorts=2 dclicks=0",
                         first_sp, n_short, n_dc, 2 + DCL);
    end
  endtask

  task automatic test_held_through_reset();
    int n_ev, sp_at;
    n_ev = 0; sp_at = -1;
    btn = 1'b1;
    #1 rst_n = 1'b0;
    #3;
    checks++;
    if (obs_v() !== 6'b0) begin
      errors++; $display("FAIL held_reset_outputs: got %b want %b", obs_v(), 6'b0);
    end
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 22; i++) begin
      cyc((i < 10) || (i == 12) || (i == 13));
      checks++;
      if (obs_v() !== exp_v) begin
        errors++; $display("FAIL held_reset i=%0d: got %b want %b", i, obs_v(), exp_v);
      end
      if (i < 10) n_ev += int'(pressed) + int'(short_press) + int'(double_click) + int'(long_press) + int'(repeat_tick);
      if (short_press) sp_at = i;
    end
    checks++;
    if (n_ev !== 0) begin
      errors++; $display("FAIL held_reset_quiet: got %0d activity want 0", n_ev);
    end
    checks++;
    if (sp_at !== 14 + DCL) begin
      errors++; $display("FAIL held_reset_short: got edge %0d want %0d", sp_at, 14 + DCL);
    end
  endtask

  task automatic test_mid_reset();
    int n_ev;
    n_ev = 0;
    for (int i = 0; i < 11; i++) cyc(1'b1);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs_v() !== 6'b0) begin
      errors++; $display("FAIL mid_reset_async: got %b want %b", obs_v(), 6'b0);
    end
    model_reset();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 24; i++) begin
      cyc((i < 8) || (i == 10) || (i == 11));
      checks++;
      if (obs_v() !== exp_v) begin
        errors++; $display("FAIL mid_reset i=%0d: got %b want %b", i, obs_v(), exp_v);
      end
      if (i < 10) n_ev += int'(short_press) + int'(double_click) + int'(long_press) + int'(repeat_tick);
    end
    checks++;
    if (n_ev !== 0) begin
      errors++; $display("FAIL mid_reset_quiet: got %0d pulses want 0", n_ev);
    end
  endtask

  task automatic test_random();
    int   len;
    logic lvl;
    lvl = 1'b0;
    for (int r = 0; r < 60; r++) begin
      lvl = ~lvl;
      len = int'($urandom_range(1, (r % 4 == 1) ? 30 : 9));
      for (int j = 0; j < len; j++) begin
        cyc(lvl);
        checks++;
        if (obs_v() !== exp_v) begin
          errors++; $display("FAIL random r=%0d j=%0d: got %b want %b", r, j, obs_v(), exp_v);
        end
      end
    end
    for (int j = 0; j < 12; j++) begin
      cyc(1'b0);
      checks++;
      if (obs_v() !== exp_v) begin
        errors++; $display("FAIL random_tail j=%0d: got %b want %b", j, obs_v(), exp_v);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_short_press();
    test_double_click();
    test_long_hold();
    test_race_long();
    test_race_wait2();
    test_held_through_reset();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
